// File: rtl/baud_generator_frac_if.sv
// rtl/baud_generator_frac_if.sv - control/status bundle for the fractional baud generator
//
// Purpose: groups the run/load controls and the baud outputs of baud_generator_frac.
// Signals:
//   Enable_i     run request (level)
//   Clear_i      synchronous abort of counter, accumulator and output
//   Load_i       one-cycle strobe capturing Divisor_i/Frac_i into the pending registers
//   Divisor_i    integer half-period D
//   Frac_i       fractional increment F per period (units of 2^-FRAC_W clock)
//   Baud_Rate_o  registered baud clock
//   Baud_rate_re one-cycle pulse at mid-period
//   Baud_rate_fe one-cycle pulse at end of period
//   Busy_o       generator is running or draining
// Modports: master drives the controls, slave is the generator.
interface baud_generator_frac_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              Enable_i;
    logic              Clear_i;
    logic              Load_i;
    logic [DIV_W-1:0]  Divisor_i;
    logic [FRAC_W-1:0] Frac_i;
    logic              Baud_Rate_o;
    logic              Baud_rate_re;
    logic              Baud_rate_fe;
    logic              Busy_o;

    modport master (
        output Enable_i, Clear_i, Load_i, Divisor_i, Frac_i,
        input  Baud_Rate_o, Baud_rate_re, Baud_rate_fe, Busy_o
    );

    modport slave (
        input  Enable_i, Clear_i, Load_i, Divisor_i, Frac_i,
        output Baud_Rate_o, Baud_rate_re, Baud_rate_fe, Busy_o
    );
endinterface

// File: rtl/baud_generator_frac.sv
// rtl/baud_generator_frac.sv - fractional-N baud clock generator with pending divisor update
//
// Purpose: produces a baud clock whose period is 2*D clocks, stretched by one clock
// whenever the fractional accumulator carries, giving an average period of
// 2*D + F/2^FRAC_W clocks. New divisors are staged in pending registers and take
// effect only on a period boundary (or at once while idle).
// Ports:
//   Bus_Clk_i  clock, rising edge
//   RST_i      asynchronous active-high reset
//   bus        baud_generator_frac_if.slave (Enable_i, Clear_i, Load_i, Divisor_i,
//              Frac_i in; Baud_Rate_o, Baud_rate_re, Baud_rate_fe, Busy_o out)
// Configuration: macro BAUD_GENERATOR_FRAC_EN enables the fractional accumulator;
// when undefined Frac_i is ignored and the period is exactly 2*D.
module baud_generator_frac #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic                  Bus_Clk_i,
    input  logic                  RST_i,
    baud_generator_frac_if.slave  bus
);

    localparam int CNT_W = DIV_W + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  da_q;
    logic [DIV_W-1:0]  dp_q;
    logic              pend_q;
    logic              baud_q;

    logic              ext;
    logic [CNT_W-1:0]  period;
    logic              re;
    logic              fe;
    logic [DIV_W-1:0]  idle_div;
    logic [DIV_W-1:0]  bnd_div;
    logic              bnd_take;

`ifdef BAUD_GENERATOR_FRAC_EN
    logic [FRAC_W-1:0] fa_q;
    logic [FRAC_W-1:0] fp_q;
    logic [FRAC_W-1:0] acc_q;
    logic              ext_q;
    logic [FRAC_W:0]   acc_sum;
    logic [FRAC_W-1:0] bnd_frac;

    assign ext      = ext_q;
    assign acc_sum  = {1'b0, acc_q} + {1'b0, fa_q};
    assign bnd_frac = bus.Load_i ? bus.Frac_i : (pend_q ? fp_q : fa_q);
`else
    logic unused_frac;

    assign ext         = 1'b0;
    assign unused_frac = ^bus.Frac_i;
`endif

    assign period = {1'b0, da_q, 1'b0} + {{(CNT_W-1){1'b0}}, ext};
    assign re     = (state_q != S_IDLE) && (cnt_q == {2'b00, da_q});
    assign fe     = (state_q != S_IDLE) && (cnt_q == period);

    // Divisor seen by the IDLE->RUN decision: the pending copy lands this same edge.
    assign idle_div = pend_q ? dp_q : da_q;

    // A Load coinciding with the boundary bypasses the pending stage.
    assign bnd_take = bus.Load_i | pend_q;
    assign bnd_div  = bus.Load_i ? bus.Divisor_i : (pend_q ? dp_q : da_q);

    assign bus.Baud_Rate_o  = baud_q;
    assign bus.Baud_rate_re = re;
    assign bus.Baud_rate_fe = fe;
    assign bus.Busy_o       = (state_q != S_IDLE);

    always_ff @(posedge Bus_Clk_i or posedge RST_i) begin
        if (RST_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            da_q    <= '0;
            dp_q    <= '0;
            pend_q  <= 1'b0;
            baud_q  <= 1'b0;
`ifdef BAUD_GENERATOR_FRAC_EN
            fa_q    <= '0;
            fp_q    <= '0;
            acc_q   <= '0;
            ext_q   <= 1'b0;
`endif
        end else begin
            // Pending capture is independent of Clear; later assignments below may
            // consume it on a boundary.
            if (bus.Load_i) begin
                dp_q   <= bus.Divisor_i;
                pend_q <= 1'b1;
`ifdef BAUD_GENERATOR_FRAC_EN
                fp_q   <= bus.Frac_i;
`endif
            end

            if (bus.Clear_i) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                baud_q  <= 1'b0;
`ifdef BAUD_GENERATOR_FRAC_EN
                acc_q   <= '0;
                ext_q   <= 1'b0;
`endif
            end else begin
                if (fe) begin
                    baud_q <= 1'b0;
                end else if (re) begin
                    baud_q <= 1'b1;
                end

                case (state_q)
                    S_IDLE: begin
                        cnt_q <= '0;
                        if (pend_q) begin
                            da_q <= dp_q;
`ifdef BAUD_GENERATOR_FRAC_EN
                            fa_q <= fp_q;
`endif
                            if (!bus.Load_i) begin
                                pend_q <= 1'b0;
                            end
                        end
                        if (bus.Enable_i && (idle_div != '0)) begin
                            state_q <= S_RUN;
                            cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end

                    S_RUN, S_DRAIN: begin
                        if (cnt_q == period) begin
`ifdef BAUD_GENERATOR_FRAC_EN
                            acc_q <= acc_sum[FRAC_W-1:0];
                            ext_q <= acc_sum[FRAC_W];
                            if (bnd_take) begin
                                fa_q <= bnd_frac;
                            end
`endif
                            if (bnd_take) begin
                                da_q   <= bnd_div;
                                pend_q <= 1'b0;
                            end
                            // A zero divisor can never reach its mid-period compare,
                            // so it parks the generator instead of counting forever.
                            if (!bus.Enable_i || (bnd_div == '0)) begin
                                state_q <= S_IDLE;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= S_RUN;
                                cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                            state_q <= bus.Enable_i ? S_RUN : S_DRAIN;
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_baud_generator_frac.sv
// tb/tb_baud_generator_frac.sv - scoreboard testbench for baud_generator_frac
module tb_baud_generator_frac;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    baud_generator_frac_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

    baud_generator_frac #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) dut (
        .Bus_Clk_i (clk),
        .RST_i     (rst),
        .bus       (bus)
    );

    typedef struct {
        bit is_fe;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  fe_log[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input bit is_fe, input int c);
        ev_t e;
        e.is_fe = is_fe;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input bit is_fe);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: %s pulse at cycle %0d, none expected",
                     is_fe ? "fe" : "re", cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.is_fe != is_fe || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL sb_pulse: got %s at cycle %0d, expected %s at cycle %0d",
                         is_fe ? "fe" : "re", cyc, e.is_fe ? "fe" : "re", e.cyc);
            end
        end
    endtask

    // Monitor: every re/fe pulse is matched against the next expected event.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.Baud_rate_re) sb_pop(1'b0);
            if (bus.Baud_rate_fe) begin
                fe_log.push_back(cyc);
                sb_pop(1'b1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_load(input int d, input int f);
        bus.Load_i    = 1'b1;
        bus.Divisor_i = DIV_W'(d);
        bus.Frac_i    = FRAC_W'(f);
        tick();
        bus.Load_i    = 1'b0;
    endtask

    task automatic stop_at(input int c);
        wait_until(c);
        bus.Clear_i  = 1'b1;
        bus.Enable_i = 1'b0;
        tick();
        bus.Clear_i  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int t;
        int p;
        int hi;
        int any;
        int tot;

        bus.Enable_i  = 1'b0;
        bus.Clear_i   = 1'b0;
        bus.Load_i    = 1'b0;
        bus.Divisor_i = '0;
        bus.Frac_i    = '0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("reset_baud", bus.Baud_Rate_o, 0);
        chk("reset_re",   bus.Baud_rate_re, 0);
        chk("reset_fe",   bus.Baud_rate_fe, 0);
        chk("reset_busy", bus.Busy_o, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // D=4 F=0: re at cnt 4, fe at cnt 8, 50% duty, then drain after enable drop
        do_load(4, 0);
        bus.Enable_i = 1'b1;
        s = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            push_ev(1'b0, s + 8 * k + 3);
            push_ev(1'b1, s + 8 * k + 7);
        end
        tick();
        chk("a_busy_run", bus.Busy_o, 1);
        wait_until(s + 8);
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.Baud_Rate_o) hi++;
            tick();
        end
        chk("a_duty_high", hi, 4);
        wait_until(s + 17);
        bus.Enable_i = 1'b0;
        wait_until(s + 25);
        chk("a_idle_busy", bus.Busy_o, 0);
        chk("a_idle_baud", bus.Baud_Rate_o, 0);

        // D=3 F=8: periods 6,6,7,6,7,... ; 16 fe-to-fe intervals span 104 clocks
        do_load(3, 8);
        bus.Enable_i = 1'b1;
        s = cyc + 1;
        t = s;
        fe_log.delete();
        for (int k = 0; k < 17; k++) begin
            p = 6;
`ifdef BAUD_GENERATOR_FRAC_EN
            if (k > 0 && (k % 2) == 0) p = 7;
`endif
            push_ev(1'b0, t + 2);
            push_ev(1'b1, t + p - 1);
            t += p;
        end
`ifdef BAUD_GENERATOR_FRAC_EN
        tot = 104;
`else
        tot = 96;
`endif
        tick();
        stop_at(t - 1);
        chk("b_fe_count", fe_log.size(), 17);
        chk("b_16_periods", (fe_log.size() == 17) ? fe_log[16] - fe_log[0] : -1, tot);

        // D=4 running, Load D=2 at cnt 3: period ends at cnt 8, then 4-clock periods
        do_load(4, 0);
        bus.Enable_i = 1'b1;
        s = cyc + 1;
        push_ev(1'b0, s + 3);
        push_ev(1'b1, s + 7);
        push_ev(1'b0, s + 9);
        push_ev(1'b1, s + 11);
        push_ev(1'b0, s + 13);
        push_ev(1'b1, s + 15);
        tick();
        wait_until(s + 2);
        do_load(2, 0);
        stop_at(s + 15);

        // D=5, Enable drop at cnt 2: drains to fe at cnt 10, then silent
        do_load(5, 0);
        bus.Enable_i = 1'b1;
        s = cyc + 1;
        push_ev(1'b0, s + 4);
        push_ev(1'b1, s + 9);
        tick();
        tick();
        bus.Enable_i = 1'b0;
        wait_until(s + 8);
        chk("d_drain_busy", bus.Busy_o, 1);
        chk("d_drain_baud", bus.Baud_Rate_o, 1);
        wait_until(s + 11);
        chk("d_idle_busy", bus.Busy_o, 0);
        chk("d_idle_baud", bus.Baud_Rate_o, 0);
        repeat (20) tick();

        // D=5, Clear at cnt 7: IDLE next cycle, restart with cnt 1 one cycle later
        do_load(5, 0);
        bus.Enable_i = 1'b1;
        s = cyc + 1;
        push_ev(1'b0, s + 4);
        tick();
        wait_until(s + 6);
        bus.Clear_i = 1'b1;
        tick();
        bus.Clear_i = 1'b0;
        chk("e_clear_busy", bus.Busy_o, 0);
        chk("e_clear_baud", bus.Baud_Rate_o, 0);
        push_ev(1'b0, s + 12);
        push_ev(1'b1, s + 17);
        tick();
        chk("e_restart_busy", bus.Busy_o, 1);
        stop_at(s + 17);

        // D=0 with Enable held: quiescent for 50 clocks
        do_load(0, 0);
        bus.Enable_i = 1'b1;
        any = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.Busy_o || bus.Baud_Rate_o) any++;
        end
        chk("f_d0_quiet", any, 0);

        // Reset mid-period: outputs drop immediately, no clock needed
        do_load(5, 0);
        s = cyc + 1;
        push_ev(1'b0, s + 4);
        tick();
        wait_until(s + 6);
        chk("f_pre_rst_baud", bus.Baud_Rate_o, 1);
        rst = 1'b1;
        #1;
        chk("f_rst_baud", bus.Baud_Rate_o, 0);
        chk("f_rst_busy", bus.Busy_o, 0);
        chk("f_rst_re",   bus.Baud_rate_re, 0);
        chk("f_rst_fe",   bus.Baud_rate_fe, 0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("f_post_rst_busy", bus.Busy_o, 0);
        bus.Enable_i = 1'b0;
        tick();

        chk("sb_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_generator_frac.md
BAUD_GENERATOR_FRAC -- requirements
Module: baud_generator_frac

Interface
REQ-001 SHALL have parameter DIV_W, default 16: divisor integer width (4..24).
REQ-002 SHALL have parameter FRAC_W, default 4: fractional divisor width (1..8).
REQ-003 SHALL have port Bus_Clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_i, input, 1: asynchronous reset, active-high.
REQ-005 SHALL have port Enable_i, input, 1: run request, level.
REQ-006 SHALL have port Clear_i, input, 1: synchronous abort of the counter, accumulator and output.
REQ-007 SHALL have port Load_i, input, 1: single-cycle strobe; captures Divisor_i/Frac_i into the pending registers.
REQ-008 SHALL have port Divisor_i, input, DIV_W: integer half-period D.
REQ-009 SHALL have port Frac_i, input, FRAC_W: fractional increment F (units of 2^-FRAC_W clock per period).
REQ-010 SHALL have port Baud_Rate_o, output, 1: registered baud clock.
REQ-011 SHALL have port Baud_rate_re, output, 1: one-cycle pulse at mid-period.
REQ-012 SHALL have port Baud_rate_fe, output, 1: one-cycle pulse at end of period.
REQ-013 SHALL have port Busy_o, output, 1: high in RUN or DRAIN.

Function
REQ-014 SHALL hold active divisor Da/Fa, pending divisor Dp/Fp with pending flag, a (DIV_W+2)-bit counter cnt, an FRAC_W-bit accumulator acc and an extend bit ext.
REQ-015 SHALL define period P = 2*Da + ext; Baud_rate_re = (state!=IDLE && cnt==Da); Baud_rate_fe = (state!=IDLE && cnt==P); both combinational from registered state.
REQ-016 SHALL set Baud_Rate_o to 1 the cycle after Baud_rate_re and to 0 the cycle after Baud_rate_fe; otherwise hold.
REQ-017 SHALL implement FSM IDLE, RUN, DRAIN; in IDLE cnt=0 and pending values are copied to Da/Fa immediately.
REQ-018 SHALL go IDLE->RUN when Enable_i=1 and Da!=0 (after any same-cycle pending copy), loading cnt=1.
REQ-019 SHALL increment cnt by 1 in RUN/DRAIN; at cnt==P, cnt<=1, {carry,acc}<=acc+Fa, ext<=carry, and pending (if set) is copied to Da/Fa, clearing the flag.
REQ-020 SHALL go RUN->DRAIN when Enable_i=0; DRAIN completes the current period and enters IDLE at cnt==P; Enable_i=1 in DRAIN returns to RUN without a gap.
REQ-021 SHALL keep Da=0 in IDLE with Enable_i=1 quiescent: no pulses, Baud_Rate_o=0, Busy_o=0.
REQ-022 SHALL, when Load_i coincides with cnt==P, apply the newly loaded value at that boundary.
REQ-023 SHALL, on Clear_i=1, force cnt=0, acc=0, ext=0, Baud_Rate_o=0, state IDLE next cycle, overriding all other events; the pending registers are kept.

Reset
REQ-024 SHALL on RST_i=1 asynchronously set state IDLE, cnt=0, acc=0, ext=0, Da=Dp=0, Fa=Fp=0, pending=0, Baud_Rate_o=0; Baud_rate_re, Baud_rate_fe and Busy_o are therefore 0.
REQ-025 SHALL resume operation on the first Bus_Clk_i rising edge after RST_i deasserts; reset during RUN/DRAIN aborts the period with no further pulses.

Configuration
REQ-026 SHALL with macro BAUD_GENERATOR_FRAC_EN defined implement acc, ext and Fa/Fp as specified.
REQ-027 SHALL with BAUD_GENERATOR_FRAC_EN undefined omit acc/Fa/Fp, ignore Frac_i, tie ext=0, giving P=2*Da exactly.

Verification
REQ-028 SHALL test D=4, F=0, Load then Enable: re at cnt=4, fe at cnt=8, period 8 clocks, Baud_Rate_o high 4 of 8 clocks.
REQ-029 SHALL test D=3, F=8, FRAC_W=4, FRAC_EN: period lengths 6,6,7,6,7,...; 16 periods total 104 clocks.
REQ-030 SHALL test D=4 running, Load D=2 at cnt=3: current period ends at cnt=8, next period 4 clocks with re at cnt=2.
REQ-031 SHALL test D=5, Enable drop at cnt=2: DRAIN, fe at cnt=10, then IDLE, Busy_o=0, Baud_Rate_o=0, no further pulses.
REQ-032 SHALL test D=5, Clear_i at cnt=7: next cycle cnt=0, Baud_Rate_o=0, IDLE; with Enable_i still 1, restart with cnt=1 one cycle later.
REQ-033 SHALL test D=0 with Enable_i=1 for 50 clocks: no re/fe pulses, Busy_o=0; RST_i mid-period: all outputs 0 immediately.
